fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch sequencer between the PC and the instruction memory. It owns the program counter and drives the word address into the combinational-read instruction memory. Each returned instruction is buffered with its PC in a small queue and handed to decode over a valid/ready handshake. It handles decode back-pressure, fetch halt and branch/jump redirects with queue flush.

## Interface
- `RESET_PC`, default 32'h0000_0000: byte PC loaded on reset; bits [1:0] must be 0.
- `DEPTH`, default 2: fetch-queue entries (≥1).
- `MEM_WORDS`, default 32: instruction-memory words; PC wraps modulo MEM_WORDS*4.
- `clk`  in  1: single clock; all state changes on posedge.
- `rst`  in  1: synchronous, active-high reset.
- `imem_addr`  out  32: word index to instruction memory = (pc >> 2) mod MEM_WORDS.
- `imem_data`  in  32: instruction at `imem_addr`, valid same cycle (combinational read).
- `halt`  in  1: level; while high no new fetches are pushed.
- `redirect_valid`  in  1: one-cycle pulse; load `redirect_pc` and flush the queue.
- `redirect_pc`  in  32: target byte address; bits [1:0] forced to 0.
- `out_valid`  out  1: queue head valid.
- `out_ready`  in  1: decode accepts head this cycle.
- `out_instr`  out  32: head instruction; 0 when `out_valid`=0.
- `out_pc`  out  32: byte PC of head instruction; 0 when `out_valid`=0.

## Operation
- States: RUN, HALTED. Reset → RUN. RUN→HALTED when `halt`=1; HALTED→RUN when `halt`=0. Transition takes effect the same cycle (gates the push combinationally); state register tracks it for observability.
- pop = `out_valid` & `out_ready`.
- push = RUN & !`halt` & !`redirect_valid` & (count<DEPTH | pop). On push: enqueue {`imem_data`, pc}; pc ← pc+4 mod MEM_WORDS*4.
- Redirect (priority over everything): queue emptied, pc ← `redirect_pc` & ~3 mod MEM_WORDS*4, no push that cycle. Any pop coincident with a redirect is still a valid handoff of the old head; decode owns discarding it.
- Redirect during HALTED: flush and pc update occur; state stays HALTED.
- Simultaneous push and pop: count unchanged, FIFO order preserved.
- Full (count=DEPTH) with no pop: no push, pc holds, `imem_addr` stable.
- Empty: `out_valid`=0; `out_instr`/`out_pc`=0.
- Wrap: pc at (MEM_WORDS-1)*4 increments to 0.

## Timing
- Reset values: pc=RESET_PC, count=0, state=RUN, `out_valid`=0, `out_instr`=0, `out_pc`=0, `imem_addr`=RESET_PC>>2.
- `imem_addr` is a function of registered pc only. No combinational path from `out_ready`, `halt` or `redirect_*` to `imem_addr`.
- Fetch latency: instruction at pc P is pushed at the end of cycle N and appears on `out` in cycle N+1. First `out_valid` is in the second cycle after `rst` deasserts.
- Redirect in cycle N: `out_valid`=0 in N+1, target fetched in N+1, and target on `out` in N+2 (2-cycle bubble).
- With `out_ready` held high, throughput is 1 instruction/cycle.
- `rst` mid-operation overrides redirect/halt/handshake. All state returns to reset values at that edge.

## Structure
- Package `fetch_pkg`: XLEN=32, INSTR_BYTES=4, default RESET_PC, state enum {RUN, HALTED}, queue entry struct {instr[31:0], pc[31:0]}.
- Sub-module `fetch_queue`: parameterised DEPTH FIFO of entries with push/pop/flush, count, full/empty. Flush beats push; simultaneous push+pop is allowed when full.
- The top level holds pc, state, push/pop logic and the address modulo.

## Test plan
- Reset then `out_ready`=1, memory word k = 32'hA000_0000+k: out sequence (pc 0, A0000000), (4, A0000001), (8, A0000002) on consecutive cycles; first valid in 2nd cycle after reset release.
- `out_ready`=0 for 5 cycles from reset: count saturates at 2, `imem_addr` holds at 2, `out_pc` holds 0. Raise `out_ready`: pcs 0, 4, 8 … follow with no gaps or duplicates.
- `redirect_valid` pulse with `redirect_pc`=32'h0000_0013 while queue full: next cycle `out_valid`=0; following cycle `out_pc`=32'h10, `out_instr`=A0000004.
- `halt`=1 for 4 cycles while `out_ready`=1: queue drains, `out_valid` falls, pc frozen. `halt`=0: fetch resumes at the frozen pc. A redirect during halt to 0x20 yields `out_pc`=0x20 after release.
- Wrap, MEM_WORDS=32: redirect to 0x7C gives `out_pc` sequence 0x7C, 0x00, 0x04.
- `rst` asserted while queue holds 2 entries and a redirect is pending: next cycle `out_valid`=0, `imem_addr`=RESET_PC>>2, and the redirect is ignored.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;
   localparam int XLEN        = 32;
   localparam int INSTR_BYTES = 4;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [0:0] {RUN = 1'b0, HALTED = 1'b1} fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-to-decode valid/ready handshake carrying an instruction and its PC.
interface fetch_unit_if;
   logic                       out_valid;
   logic                       out_ready;
   logic [fetch_pkg::XLEN-1:0] out_instr;
   logic [fetch_pkg::XLEN-1:0] out_pc;

   modport master (output out_valid, output out_instr, output out_pc, input out_ready);
   modport slave  (input out_valid, input out_instr, input out_pc, output out_ready);
endinterface

// File: rtl/fetch_queue.sv
// Circular FIFO of fetched {instr, pc} entries; flush wins over push and pop.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  fetch_entry_t     push_entry,
   input  logic             pop,
   input  logic             flush,
   output fetch_entry_t     head,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);
   fetch_entry_t     mem_q [DEPTH];
   fetch_entry_t     mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

   // A full queue still accepts a push when the head leaves in the same cycle.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
         end
         if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
         if (do_push && !do_pop)      count_d = count_q + 1'b1;
         else if (do_pop && !do_push) count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage needs no reset; occupancy is tracked by count_q.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: owns the PC, reads imem, queues {instr, pc} for decode.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter int              DEPTH     = 2,
   parameter int              MEM_WORDS = 32
) (
   input  logic            clk,
   input  logic            rst,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_data,
   input  logic            halt,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   fetch_unit_if.master    dec
);
   localparam logic [XLEN-1:0] MEM_W = XLEN'(MEM_WORDS);
   localparam int              CNT_W = $clog2(DEPTH + 1);

   logic [XLEN-1:0]  pc_q, pc_d;
   fetch_state_e     state_q, state_d;
   logic [XLEN-1:0]  inc_word, tgt_word;
   logic             push, pop;
   fetch_entry_t     push_entry, head;
   logic             q_full, q_empty;
   logic [CNT_W-1:0] q_count;

   // Address depends on the registered PC only, never on this cycle's inputs.
   assign imem_addr = {2'b00, pc_q[XLEN-1:2]} % MEM_W;
   assign pop       = dec.out_valid & dec.out_ready;

   always_comb begin
      state_d  = halt ? HALTED : RUN;
      inc_word = imem_addr + 32'd1;
      if (inc_word == MEM_W) inc_word = '0;
      tgt_word = {2'b00, redirect_pc[XLEN-1:2]} % MEM_W;
      push     = (state_d == RUN) & ~redirect_valid & (~q_full | pop);
      pc_d     = pc_q;
      if (redirect_valid) pc_d = {tgt_word[XLEN-3:0], 2'b00};
      else if (push)      pc_d = {inc_word[XLEN-3:0], 2'b00};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         state_q <= RUN;
      end else begin
         pc_q    <= pc_d;
         state_q <= state_d;
      end
   end

   assign push_entry = '{instr: imem_data, pc: {imem_addr[XLEN-3:0], 2'b00}};

   fetch_queue #(.DEPTH(DEPTH)) u_queue (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .flush      (redirect_valid),
      .head       (head),
      .count      (q_count),
      .full       (q_full),
      .empty      (q_empty)
   );

   assign dec.out_valid = ~q_empty;
   assign dec.out_instr = q_empty ? '0 : head.instr;
   assign dec.out_pc    = q_empty ? '0 : head.pc;

   logic unused_ok;
   assign unused_ok = ^{state_q, q_count, pc_q[1:0], redirect_pc[1:0],
                        inc_word[XLEN-1:XLEN-2], tgt_word[XLEN-1:XLEN-2],
                        imem_addr[XLEN-1:XLEN-2]};
endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit with a combinational word-indexed memory.
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] imem_addr, imem_data;
   logic        halt, redirect_valid;
   logic [31:0] redirect_pc;
   int          n_cmp = 0;
   int          n_bad = 0;

   fetch_unit_if dif ();

   fetch_unit #(.RESET_PC(32'h0), .DEPTH(2), .MEM_WORDS(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .halt           (halt),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .dec            (dif)
   );

   always #5 clk = ~clk;
   assign imem_data = 32'hA000_0000 + imem_addr;

   typedef struct {
      logic        rst, halt, rdv, rdy;
      logic [31:0] rpc;
      logic        ev;
      logic [31:0] epc, eaddr;
   } vec_t;

   localparam int NV = 37;
   vec_t tbl [NV];

   function automatic vec_t mk(logic r, logic h, logic rv, logic [31:0] rp, logic rd,
                               logic ev, logic [31:0] epc, logic [31:0] ea);
      vec_t v;
      v.rst = r; v.halt = h; v.rdv = rv; v.rpc = rp; v.rdy = rd;
      v.ev = ev; v.epc = epc; v.eaddr = ea;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic chk_out(input string nm, input logic ev, input logic [31:0] epc,
                          input logic [31:0] ea);
      chk({nm, ".valid"}, {31'd0, dif.out_valid}, {31'd0, ev});
      chk({nm, ".pc"}, dif.out_pc, ev ? epc : 32'h0);
      chk({nm, ".instr"}, dif.out_instr, ev ? 32'hA000_0000 + (epc >> 2) : 32'h0);
      chk({nm, ".addr"}, imem_addr, ea);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      //               rst h rdv rpc       rdy  ev  epc      addr
      tbl[0]  = mk(1, 0, 0, 32'h0,  1,  0, 32'h00, 0);
      tbl[1]  = mk(0, 0, 0, 32'h0,  1,  0, 32'h00, 0);
      tbl[2]  = mk(0, 0, 0, 32'h0,  1,  1, 32'h00, 1);
      tbl[3]  = mk(0, 0, 0, 32'h0,  1,  1, 32'h04, 2);
      tbl[4]  = mk(0, 0, 0, 32'h0,  1,  1, 32'h08, 3);
      tbl[5]  = mk(1, 0, 0, 32'h0,  1,  1, 32'h0C, 4);
      tbl[6]  = mk(0, 0, 0, 32'h0,  0,  0, 32'h00, 0);
      tbl[7]  = mk(0, 0, 0, 32'h0,  0,  1, 32'h00, 1);
      tbl[8]  = mk(0, 0, 0, 32'h0,  0,  1, 32'h00, 2);
      tbl[9]  = mk(0, 0, 0, 32'h0,  0,  1, 32'h00, 2);
      tbl[10] = mk(0, 0, 0, 32'h0,  0,  1, 32'h00, 2);
      tbl[11] = mk(0, 0, 0, 32'h0,  1,  1, 32'h00, 2);
      tbl[12] = mk(0, 0, 0, 32'h0,  1,  1, 32'h04, 3);
      tbl[13] = mk(0, 0, 0, 32'h0,  0,  1, 32'h08, 4);
      tbl[14] = mk(0, 0, 1, 32'h13, 0,  1, 32'h08, 4);
      tbl[15] = mk(0, 0, 0, 32'h0,  1,  0, 32'h00, 4);
      tbl[16] = mk(0, 0, 0, 32'h0,  1,  1, 32'h10, 5);
      tbl[17] = mk(0, 1, 0, 32'h0,  1,  1, 32'h14, 6);
      tbl[18] = mk(0, 1, 0, 32'h0,  1,  0, 32'h00, 6);
      tbl[19] = mk(0, 1, 0, 32'h0,  1,  0, 32'h00, 6);
      tbl[20] = mk(0, 1, 0, 32'h0,  1,  0, 32'h00, 6);
      tbl[21] = mk(0, 0, 0, 32'h0,  1,  0, 32'h00, 6);
      tbl[22] = mk(0, 1, 0, 32'h0,  1,  1, 32'h18, 7);
      tbl[23] = mk(0, 1, 1, 32'h20, 1,  0, 32'h00, 7);
      tbl[24] = mk(0, 1, 0, 32'h0,  1,  0, 32'h00, 8);
      tbl[25] = mk(0, 0, 0, 32'h0,  1,  0, 32'h00, 8);
      tbl[26] = mk(0, 0, 0, 32'h0,  1,  1, 32'h20, 9);
      tbl[27] = mk(0, 0, 1, 32'h7C, 1,  1, 32'h24, 10);
      tbl[28] = mk(0, 0, 0, 32'h0,  1,  0, 32'h00, 31);
      tbl[29] = mk(0, 0, 0, 32'h0,  1,  1, 32'h7C, 0);
      tbl[30] = mk(0, 0, 0, 32'h0,  1,  1, 32'h00, 1);
      tbl[31] = mk(0, 0, 0, 32'h0,  1,  1, 32'h04, 2);
      tbl[32] = mk(0, 0, 0, 32'h0,  0,  1, 32'h08, 3);
      tbl[33] = mk(0, 0, 0, 32'h0,  0,  1, 32'h08, 4);
      tbl[34] = mk(1, 0, 1, 32'h40, 0,  1, 32'h08, 4);
      tbl[35] = mk(0, 0, 0, 32'h0,  0,  0, 32'h00, 0);
      tbl[36] = mk(0, 0, 0, 32'h0,  1,  1, 32'h00, 1);

      rst = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      dif.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Each row: drive this cycle's inputs, check registered outputs, then clock.
      for (int i = 0; i < NV; i++) begin
         rst = tbl[i].rst; halt = tbl[i].halt; redirect_valid = tbl[i].rdv;
         redirect_pc = tbl[i].rpc; dif.out_ready = tbl[i].rdy;
         chk_out($sformatf("row%0d", i), tbl[i].ev, tbl[i].epc, tbl[i].eaddr);
         @(posedge clk);
         #1;
      end

      // Streaming walk across the wrap point, with a no-comb-path probe on imem_addr.
      rst = 1'b1; halt = 1'b0; redirect_valid = 1'b0; dif.out_ready = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      seen = 1'b0;
      for (int t = 0; t < 5 && !seen; t++) begin
         if (dif.out_valid) seen = 1'b1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      chk("walk.first_valid", {31'd0, seen}, 32'd1);
      for (int k = 0; k < 40; k++) begin
         chk_out($sformatf("walk%0d", k), 1'b1, 32'((k % 32) * 4), 32'((k + 1) % 32));
         if (k == 10) begin
            halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40; dif.out_ready = 1'b0;
            #1;
            chk("walk.addr_no_comb", imem_addr, 32'd11);
            halt = 1'b0; redirect_valid = 1'b0; dif.out_ready = 1'b1;
            #1;
         end
         @(posedge clk);
         #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
